// File: rtl/btn_debounce.sv
// Button front end: per channel, a two-flop synchroniser feeds a debounce counter.
// It produces a stable level plus single-cycle press, release and long-press pulses.
module btn_debounce #(
  parameter int N_BTN           = 3,
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int LONG_CYCLES     = 12000000
) (
  input  logic             CLK,
  input  logic             BTN_N,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_long
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(LONG_CYCLES);

  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_PRE = HW'(LONG_CYCLES - 2);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic [HW-1:0] r_hcnt;
    logic          r_level;
    logic          r_press;
    logic          r_release;
    logic          r_long;
    logic          w_s;
    logic          w_diff;
    logic          w_accept;

    assign w_s      = r_sync[1];
    assign w_diff   = w_s ^ r_level;
    assign w_accept = w_diff && (r_cnt == CNT_MAX);

    always_ff @(posedge CLK or negedge BTN_N) begin
      if (!BTN_N) begin
        r_sync <= '0;
      end else begin
        r_sync <= {r_sync[0], btn_raw[i]};
      end
    end

    // Any return to the accepted level restarts the stability count.
    always_ff @(posedge CLK or negedge BTN_N) begin
      if (!BTN_N) begin
        r_cnt     <= '0;
        r_level   <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
      end else begin
        r_press   <= w_accept && w_s;
        r_release <= w_accept && !w_s;
        if (!w_diff) begin
          r_cnt <= '0;
        end else if (r_cnt == CNT_MAX) begin
          r_cnt   <= '0;
          r_level <= w_s;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end

    // Hold counter saturates, so the long pulse fires once per press.
    always_ff @(posedge CLK or negedge BTN_N) begin
      if (!BTN_N) begin
        r_hcnt <= '0;
        r_long <= 1'b0;
      end else begin
        r_long <= r_level && (r_hcnt == HOLD_PRE);
        if (!r_level) begin
          r_hcnt <= '0;
        end else if (r_hcnt != HOLD_MAX) begin
          r_hcnt <= r_hcnt + 1'b1;
        end
      end
    end

    assign btn_level[i]   = r_level;
    assign btn_press[i]   = r_press;
    assign btn_release[i] = r_release;
    assign btn_long[i]    = r_long;
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce: stimulus queues expected pulse events,
// a monitor pops and compares them whenever the DUT emits a pulse.
module tb_btn_debounce;

  localparam int KIND_PRESS   = 0;
  localparam int KIND_RELEASE = 1;
  localparam int KIND_LONG    = 2;

  typedef struct {
    int cyc;
    int ch;
    int kind;
  } ev_t;

  logic       CLK;
  logic       BTN_N;
  logic [1:0] btn_raw;
  logic [1:0] btn_level;
  logic [1:0] btn_press;
  logic [1:0] btn_release;
  logic [1:0] btn_long;

  int  cyc;
  int  nVec;
  int  nErr;
  ev_t expQ[$];

  btn_debounce #(
    .N_BTN(2),
    .DEBOUNCE_CYCLES(8),
    .LONG_CYCLES(32)
  ) dut (
    .CLK(CLK),
    .BTN_N(BTN_N),
    .btn_raw(btn_raw),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .btn_release(btn_release),
    .btn_long(btn_long)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic pushEvent(input int c, input int ch, input int kind);
    ev_t e;
    e.cyc  = c;
    e.ch   = ch;
    e.kind = kind;
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic [1:0] raw, input int hold);
    btn_raw = raw;
    repeat (hold) @(negedge CLK);
  endtask

  task automatic waitUntil(input int t);
    while (cyc < t) @(negedge CLK);
  endtask

  task automatic checkOutput(input string name, input logic [7:0] exp);
    logic [7:0] act;
    act = {btn_long, btn_release, btn_press, btn_level};
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("[TB] FAIL %s at cycle %0d: {long,rel,press,level} got %b expected %b",
               name, cyc, act, exp);
    end
  endtask

  // Monitor: drop overdue expectations as misses, then match each emitted pulse.
  always @(negedge CLK) begin
    ev_t        e;
    logic [2:0] pulses;
    while (expQ.size() > 0 && expQ[0].cyc < cyc) begin
      e = expQ.pop_front();
      nVec++;
      nErr++;
      $display("[TB] FAIL missed_event: ch %0d kind %0d expected at cycle %0d, not observed by cycle %0d",
               e.ch, e.kind, e.cyc, cyc);
    end
    for (int ch = 0; ch < 2; ch++) begin
      pulses = {btn_long[ch], btn_release[ch], btn_press[ch]};
      for (int k = 0; k < 3; k++) begin
        if (pulses[k]) begin
          nVec++;
          if (expQ.size() == 0) begin
            nErr++;
            $display("[TB] FAIL unexpected_event: ch %0d kind %0d at cycle %0d, expected none",
                     ch, k, cyc);
          end else begin
            e = expQ.pop_front();
            if (e.cyc != cyc || e.ch != ch || e.kind != k) begin
              nErr++;
              $display("[TB] FAIL event_match: got ch %0d kind %0d cycle %0d, expected ch %0d kind %0d cycle %0d",
                       ch, k, cyc, e.ch, e.kind, e.cyc);
            end
          end
        end
      end
    end
  end

  initial begin
    int c;
    int d;
    int m;
    int p;
    int r;
    int e;
    nVec    = 0;
    nErr    = 0;
    BTN_N   = 1'b0;
    btn_raw = 2'b11;

    // Reset held with both buttons pressed: everything stays clear.
    repeat (5) begin
      @(negedge CLK);
      checkOutput("reset_hold", 8'h00);
    end
    btn_raw = 2'b00;
    @(negedge CLK);
    BTN_N = 1'b1;
    repeat (3) @(negedge CLK);
    checkOutput("post_reset", 8'h00);

    // Clean press and release on channel 0.
    c = cyc;
    pushEvent(c + 10, 0, KIND_PRESS);
    applyStimulus(2'b01, 9);
    checkOutput("clean_pre", 8'h00);
    @(negedge CLK);
    checkOutput("clean_press", 8'h05);
    @(negedge CLK);
    checkOutput("clean_press_end", 8'h01);
    @(negedge CLK);
    d = cyc;
    pushEvent(d + 10, 0, KIND_RELEASE);
    applyStimulus(2'b00, 10);
    checkOutput("clean_release", 8'h10);
    repeat (5) @(negedge CLK);

    // Bounce on channel 0, then held long enough for one long pulse.
    c = cyc;
    applyStimulus(2'b01, 5);
    applyStimulus(2'b00, 1);
    btn_raw = 2'b01;
    m = cyc + 1;
    p = m + 9;
    pushEvent(p, 0, KIND_PRESS);
    pushEvent(p + 31, 0, KIND_LONG);
    waitUntil(m + 8);
    checkOutput("bounce_pre", 8'h00);
    waitUntil(p + 31);
    checkOutput("long_pulse0", 8'h41);
    waitUntil(p + 40);
    btn_raw = 2'b00;
    r = cyc + 1;
    pushEvent(r + 9, 0, KIND_RELEASE);
    waitUntil(r + 9);
    checkOutput("long_release0", 8'h10);
    repeat (10) @(negedge CLK);

    // Seven-cycle glitch on channel 1 is rejected.
    applyStimulus(2'b10, 7);
    applyStimulus(2'b00, 12);
    checkOutput("glitch_level", 8'h00);

    // Reset while channel 1 is held, then re-press after reset.
    c = cyc;
    pushEvent(c + 10, 1, KIND_PRESS);
    applyStimulus(2'b10, 15);
    checkOutput("hold_level1", 8'h02);
    #2 BTN_N = 1'b0;
    #1 checkOutput("async_reset", 8'h00);
    @(negedge CLK);
    @(negedge CLK);
    checkOutput("reset_midhold", 8'h00);
    BTN_N = 1'b1;
    e = cyc;
    pushEvent(e + 10, 1, KIND_PRESS);
    pushEvent(e + 41, 1, KIND_LONG);
    waitUntil(e + 10);
    checkOutput("repress1", 8'h0A);
    waitUntil(e + 41);
    checkOutput("long_pulse1", 8'h82);
    waitUntil(e + 45);
    pushEvent(e + 55, 1, KIND_RELEASE);
    applyStimulus(2'b00, 15);
    checkOutput("final_idle", 8'h00);

    nVec++;
    if (expQ.size() != 0) begin
      nErr++;
      $display("[TB] FAIL queue_drain: %0d events outstanding, expected 0", expQ.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
